// File: rtl/daq_buf_pkg.sv
// Shared defaults and ring-pointer arithmetic for the DAQ ring buffer.
package daq_buf_pkg;

  localparam int DW_DEF     = 34;
  localparam int AW_DEF     = 8;
  localparam int GUARD_DEF  = 10;
  localparam int DROP_CNT_W = 16;

  // Modular distance a - b on an aw-bit ring; callers cast down to their width.
  function automatic logic [31:0] ring_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned aw);
    logic [31:0] mask_s;
    mask_s = (32'd1 << aw) - 32'd1;
    return (a - b) & mask_s;
  endfunction

endpackage

// File: rtl/ring_ram.sv
// Simple dual-port RAM: one write port, one registered read port, write-first on collision.
module ring_ram #(
  parameter int DW = 34,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] rdata_r;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads and forwards a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DW{1'b0}};
    end else if (re) begin
      if (we && (waddr == raddr)) begin
        rdata_r <= wdata;
      end else begin
        rdata_r <= mem_r[raddr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/daq_ring_buffer.sv
// Ring buffer for raw frames awaiting L1A readout; owns write and oldest-pinned pointers.
module daq_ring_buffer
  import daq_buf_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DW-1:0]         wr_data,
  input  logic [AW-1:0]         wblock,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DW-1:0]         rd_data,
  output logic                  rd_valid,
  input  logic                  rel_en,
  input  logic [AW-1:0]         rel_addr,
  output logic                  rel_err,
  output logic [AW-1:0]         wptr,
  output logic [AW-1:0]         bptr,
  output logic [AW-1:0]         used,
  output logic                  full,
  output logic                  ovf,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_ovf
);

  logic [AW-1:0]         wptr_r;
  logic [AW-1:0]         bptr_r;
  logic                  rd_valid_r;
  logic                  rel_err_r;
  logic                  ovf_r;
  logic [DROP_CNT_W-1:0] drop_cnt_r;

  logic [AW-1:0] space_s;
  logic [AW-1:0] used_s;
  logic [AW-1:0] rel_dist_s;
  logic [AW+1:0] thr_s;
  logic          full_s;
  logic          wr_ok_s;
  logic          drop_s;
  logic          rel_ok_s;

  assign space_s    = AW'(ring_diff(32'(bptr_r), 32'(wptr_r), AW));
  assign used_s     = AW'(ring_diff(32'(wptr_r), 32'(bptr_r), AW));
  assign rel_dist_s = AW'(ring_diff(32'(rel_addr), 32'(bptr_r), AW));

  // Threshold carries two extra bits so wblock + GUARD never wraps below space.
  assign thr_s   = {2'b00, wblock} + (AW+2)'(GUARD);
  assign full_s  = !((space_s == {AW{1'b0}}) || ({2'b00, space_s} > thr_s));
  assign wr_ok_s = wr_en && !full_s;
  assign drop_s  = wr_en && full_s;
  assign rel_ok_s = rel_en && (rel_dist_s <= used_s);

  // Pointer, release-error and read-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r     <= {AW{1'b0}};
      bptr_r     <= {AW{1'b0}};
      rd_valid_r <= 1'b0;
      rel_err_r  <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (rel_ok_s) begin
        bptr_r <= rel_addr;
      end
      rd_valid_r <= rd_en;
      rel_err_r  <= rel_en && !rel_ok_s;
    end
  end

  // Overflow accounting; an explicit clear beats a drop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (clr_ovf) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= {DROP_CNT_W{1'b0}};
    end else if (drop_s) begin
      ovf_r <= 1'b1;
      if (drop_cnt_r != {DROP_CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  ring_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok_s),
    .waddr (wptr_r),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign wptr     = wptr_r;
  assign bptr     = bptr_r;
  assign used     = used_s;
  assign full     = full_s;
  assign rd_valid = rd_valid_r;
  assign rel_err  = rel_err_r;
  assign ovf      = ovf_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_daq_ring_buffer.sv
// Directed self-checking bench for daq_ring_buffer with hand-computed expectations.
module tb_daq_ring_buffer;

  localparam int DW = 34;
  localparam int AW = 8;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] wblock;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rel_en;
  logic [AW-1:0] rel_addr;
  logic          rel_err;
  logic [AW-1:0] wptr;
  logic [AW-1:0] bptr;
  logic [AW-1:0] used;
  logic          full;
  logic          ovf;
  logic [15:0]   drop_cnt;
  logic          clr_ovf;

  int checks_cnt;
  int fail_cnt;

  daq_ring_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wblock   (wblock),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rel_en   (rel_en),
    .rel_addr (rel_addr),
    .rel_err  (rel_err),
    .wptr     (wptr),
    .bptr     (bptr),
    .used     (used),
    .full     (full),
    .ovf      (ovf),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_n(input int n, input logic [DW-1:0] base);
    wr_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + DW'(i);
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic release_to(input logic [AW-1:0] addr);
    rel_en   = 1'b1;
    rel_addr = addr;
    step();
    rel_en   = 1'b0;
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    wblock   = 8'd8;
    rd_en    = 1'b0;
    rd_addr  = 8'd0;
    rel_en   = 1'b0;
    rel_addr = 8'd0;
    clr_ovf  = 1'b0;
    #2;

    // Reset state
    do_reset();
    check_eq("rst_wptr", 64'(wptr), 64'd0);
    check_eq("rst_bptr", 64'(bptr), 64'd0);
    check_eq("rst_used", 64'(used), 64'd0);
    check_eq("rst_full", 64'(full), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_rdv", 64'(rd_valid), 64'd0);
    check_eq("rst_rdd", 64'(rd_data), 64'd0);

    // Basic write/read
    write_n(5, 34'h1);
    rd_en   = 1'b1;
    rd_addr = 8'd2;
    step();
    rd_en = 1'b0;
    check_eq("basic_rdd", 64'(rd_data), 64'h3);
    check_eq("basic_rdv", 64'(rd_valid), 64'd1);
    check_eq("basic_used", 64'(used), 64'd5);
    check_eq("basic_wptr", 64'(wptr), 64'd5);
    check_eq("basic_full", 64'(full), 64'd0);
    step();
    check_eq("idle_rdv", 64'(rd_valid), 64'd0);
    check_eq("idle_rdd_hold", 64'(rd_data), 64'h3);

    // Full threshold with wblock=8
    do_reset();
    wblock = 8'd8;
    write_n(237, 34'h100);
    check_eq("thr_237_full", 64'(full), 64'd0);
    check_eq("thr_237_wptr", 64'(wptr), 64'd237);
    write_n(1, 34'h200);
    check_eq("thr_238_full", 64'(full), 64'd1);
    write_n(1, 34'h201);
    check_eq("drop_wptr", 64'(wptr), 64'd238);
    check_eq("drop_ovf", 64'(ovf), 64'd1);
    check_eq("drop_cnt1", 64'(drop_cnt), 64'd1);
    write_n(1, 34'h202);
    check_eq("drop_cnt2", 64'(drop_cnt), 64'd2);
    wr_en   = 1'b1;
    clr_ovf = 1'b1;
    step();
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    check_eq("clr_ovf", 64'(ovf), 64'd0);
    check_eq("clr_drop", 64'(drop_cnt), 64'd0);

    // Wide block: full whenever non-empty
    release_to(8'd238);
    check_eq("wide_used0", 64'(used), 64'd0);
    wblock = 8'd255;
    #1;
    check_eq("wide_empty_full", 64'(full), 64'd0);
    write_n(1, 34'h300);
    check_eq("wide_full", 64'(full), 64'd1);
    release_to(8'd239);
    check_eq("wide_rel_used", 64'(used), 64'd0);
    check_eq("wide_rel_full", 64'(full), 64'd0);
    wblock = 8'd8;

    // Wrap and release validation
    do_reset();
    write_n(200, 34'h0);
    release_to(8'd200);
    check_eq("wrap_bptr200", 64'(bptr), 64'd200);
    check_eq("wrap_used0", 64'(used), 64'd0);
    write_n(100, 34'h1000);
    check_eq("wrap_wptr", 64'(wptr), 64'd44);
    check_eq("wrap_bptr", 64'(bptr), 64'd200);
    check_eq("wrap_used", 64'(used), 64'd100);
    release_to(8'd50);
    check_eq("bad_rel_err", 64'(rel_err), 64'd1);
    check_eq("bad_rel_bptr", 64'(bptr), 64'd200);
    step();
    check_eq("rel_err_pulse", 64'(rel_err), 64'd0);
    release_to(8'd30);
    check_eq("good_rel_err", 64'(rel_err), 64'd0);
    check_eq("good_rel_bptr", 64'(bptr), 64'd30);
    check_eq("good_rel_used", 64'(used), 64'd14);

    // Write and release on the same edge
    wr_en    = 1'b1;
    wr_data  = 34'h55;
    rel_en   = 1'b1;
    rel_addr = 8'd44;
    step();
    wr_en  = 1'b0;
    rel_en = 1'b0;
    check_eq("sim_wptr", 64'(wptr), 64'd45);
    check_eq("sim_bptr", 64'(bptr), 64'd44);
    check_eq("sim_used", 64'(used), 64'd1);

    // Same-address write and read: new data returned (old mem[45] is 0x2d)
    wr_en   = 1'b1;
    wr_data = 34'hAB;
    rd_en   = 1'b1;
    rd_addr = 8'd45;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_eq("wf_rdd", 64'(rd_data), 64'hAB);
    check_eq("wf_rdv", 64'(rd_valid), 64'd1);
    rd_en   = 1'b1;
    rd_addr = 8'd46;
    step();
    rd_en = 1'b0;
    check_eq("old_rdd", 64'(rd_data), 64'h2E);

    // Mid-operation reset with used=120, ovf=1, rd_valid=1
    write_n(118, 34'h2000);
    check_eq("pre_used", 64'(used), 64'd120);
    wblock  = 8'd255;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    rd_addr = 8'd0;
    step();
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    wblock = 8'd8;
    check_eq("pre_ovf", 64'(ovf), 64'd1);
    check_eq("pre_rdv", 64'(rd_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_wptr", 64'(wptr), 64'd0);
    check_eq("async_bptr", 64'(bptr), 64'd0);
    check_eq("async_used", 64'(used), 64'd0);
    check_eq("async_ovf", 64'(ovf), 64'd0);
    check_eq("async_rdv", 64'(rd_valid), 64'd0);
    #3;
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
